reg_file_reader: RTL and testbench

//  Read-side sequencer for the W x L register file: walks an inclusive address

---
 rtl/reg_file_reader.sv | 175 +++++++++++++++++
 tb/tb_reg_file_reader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_reader.sv
// Read-side sequencer: walks [first..last] on the register file read port and
// streams (addr, data) words over valid/ready. Optional macro CHECKSUM_EN appends a sum word.
module reg_file_reader #(
  parameter int W = 7,
  parameter int N = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   first,
  input  logic [3:0]   last,
  output logic [3:0]   rs,
  input  logic [W:0]   s,
  output logic [W:0]   out_data,
  output logic [3:0]   out_addr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam logic [3:0] N_ADDR = 4'(N);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
`ifdef CHECKSUM_EN
    , S_SUM = 2'd3
`endif
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_ptr;
  logic [3:0] r_last;
  logic [3:0] w_ptr_next;
  logic       w_range_ok;
  logic       w_slot_free;
  logic       w_accept;
  logic       w_reject;
  logic       w_capture;
  logic       w_sum_emit;
  logic       w_drain_ack;
`ifdef CHECKSUM_EN
  logic [W:0] r_sum;
`endif

  assign w_range_ok  = (first <= N_ADDR) && (last <= N_ADDR);
  assign w_slot_free = !out_valid || out_ready;
  assign w_ptr_next  = (r_ptr == N_ADDR) ? 4'd0 : r_ptr + 4'd1;
  assign rs          = (r_state == S_READ) ? r_ptr : 4'd0;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_capture   = 1'b0;
    w_sum_emit  = 1'b0;
    w_drain_ack = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && w_range_ok) begin
          w_accept = 1'b1;
          w_next   = S_READ;
        end else if (start) begin
          w_reject = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_READ: begin
        if (w_slot_free && (r_ptr == r_last)) begin
          w_capture = 1'b1;
`ifdef CHECKSUM_EN
          w_next    = S_SUM;
`else
          w_next    = S_DRAIN;
`endif
        end else if (w_slot_free) begin
          w_capture = 1'b1;
        end else begin
          w_next = S_READ;
        end
      end
`ifdef CHECKSUM_EN
      S_SUM: begin
        if (w_slot_free) begin
          w_sum_emit = 1'b1;
          w_next     = S_DRAIN;
        end else begin
          w_next = S_SUM;
        end
      end
`endif
      S_DRAIN: begin
        if (out_valid && out_ready) begin
          w_drain_ack = 1'b1;
          w_next      = S_IDLE;
        end else begin
          w_next = S_DRAIN;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath: pointer, output slot, status pulses; bounds are latched at start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr     <= 4'd0;
      r_last    <= 4'd0;
      out_data  <= '0;
      out_addr  <= 4'd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef CHECKSUM_EN
      r_sum     <= '0;
`endif
    end else begin
      done <= w_drain_ack;
      err  <= w_reject;
      if (w_accept) begin
        r_ptr  <= first;
        r_last <= last;
        busy   <= 1'b1;
`ifdef CHECKSUM_EN
        r_sum  <= '0;
`endif
      end else if (w_capture) begin
        out_data  <= s;
        out_addr  <= r_ptr;
        out_valid <= 1'b1;
`ifdef CHECKSUM_EN
        r_sum     <= r_sum + s;
        out_last  <= 1'b0;
`else
        out_last  <= (r_ptr == r_last);
`endif
        if (r_ptr != r_last) begin
          r_ptr <= w_ptr_next;
        end
`ifdef CHECKSUM_EN
      end else if (w_sum_emit) begin
        out_data  <= r_sum;
        out_addr  <= 4'd0;
        out_valid <= 1'b1;
        out_last  <= 1'b1;
`endif
      end else if (w_drain_ack) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        busy      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_reader.sv
// Randomized bench for reg_file_reader: two instances (N=15 and N=7) share stimulus and
// are compared against an arithmetic reference of the expected word list per scan.
module tb_reg_file_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, out_ready;
  logic [3:0] first, last;
  logic [7:0] regs [16];

  logic [3:0] rs        [2];
  logic [7:0] s         [2];
  logic [7:0] out_data  [2];
  logic [3:0] out_addr  [2];
  logic       out_valid [2];
  logic       out_last  [2];
  logic       busy      [2];
  logic       done      [2];
  logic       err       [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Expected word lists per instance
  logic [3:0] e_addr [2][20];
  logic [7:0] e_data [2][20];
  int         e_cnt  [2];
  bit         e_err  [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    reg_file_reader #(.W(7), .N((g == 0) ? 15 : 7)) dut (
      .clk(clk), .reset(reset), .start(start), .first(first), .last(last),
      .rs(rs[g]), .s(s[g]), .out_data(out_data[g]), .out_addr(out_addr[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready), .out_last(out_last[g]),
      .busy(busy[g]), .done(done[g]), .err(err[g])
    );
    assign s[g] = regs[rs[g]];
  end

  function automatic int nval(input int g);
    return (g == 0) ? 15 : 7;
  endfunction

  task automatic check(input int g, input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h", tag, g, got, exp);
    end
  endtask

  task automatic fill_regs();
    regs[0] = 8'h00;
    for (int i = 1; i < 16; i++) regs[i] = 8'($urandom);
  endtask

  // Reference: word k of a scan is address (first+k) mod (N+1)
  task automatic build_expect(input int f, input int l);
    for (int g = 0; g < 2; g++) begin
      int n, cnt, sum, a;
      n = nval(g);
      if (f > n || l > n) begin
        e_err[g] = 1'b1;
        e_cnt[g] = 0;
      end else begin
        e_err[g] = 1'b0;
        cnt = (l >= f) ? (l - f + 1) : ((n + 1) - f + l + 1);
        sum = 0;
        for (int k = 0; k < cnt; k++) begin
          a = (f + k) % (n + 1);
          e_addr[g][k] = 4'(a);
          e_data[g][k] = regs[a];
          sum += int'(regs[a]);
        end
`ifdef CHECKSUM_EN
        e_addr[g][cnt] = 4'd0;
        e_data[g][cnt] = 8'(sum);
        cnt++;
`endif
        e_cnt[g] = cnt;
      end
    end
  endtask

  // mode 0: ready held 1, mode 1: ready toggles, mode 2: random ready plus stray starts
  task automatic run_scan(input int f, input int l, input int mode);
    int          idx   [2];
    bit          fin   [2];
    bit          xl    [2];
    bit          stall [2];
    logic [13:0] snap  [2];
    bit          quiet;
    build_expect(f, l);
    for (int g = 0; g < 2; g++) begin
      idx[g] = 0; fin[g] = 1'b0; xl[g] = 1'b0; stall[g] = 1'b0; snap[g] = '0;
    end
    @(negedge clk);
    start = 1'b1; first = 4'(f); last = 4'(l); out_ready = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (e_err[g] && !fin[g]) begin
          check(g, "err_pulse", err[g], (c == 1));
          check(g, "err_busy", busy[g], 1'b0);
          check(g, "err_valid", out_valid[g], 1'b0);
          if (c == 3) fin[g] = 1'b1;
        end else if (!fin[g]) begin
          check(g, "done", done[g], xl[g]);
          if (xl[g]) begin
            fin[g] = 1'b1;
            check(g, "busy_end", busy[g], 1'b0);
            check(g, "valid_end", out_valid[g], 1'b0);
          end else begin
            check(g, "busy", busy[g], 1'b1);
            if (stall[g])
              check(g, "stable", {out_valid[g], out_last[g], out_addr[g], out_data[g]}, snap[g]);
            if (c == 1) begin
              check(g, "lat_idle", out_valid[g], 1'b0);
              check(g, "err_quiet", err[g], 1'b0);
            end
            if (c == 2) check(g, "lat_first", out_valid[g], 1'b1);
            if (mode == 0 && c >= 2) check(g, "thruput", out_valid[g], 1'b1);
          end
        end
      end
      quiet = (mode == 2) && !e_err[0] && !e_err[1];
      for (int g = 0; g < 2; g++) if (fin[g] || xl[g]) quiet = 1'b0;
      start = quiet && ($urandom_range(0, 3) == 0);
      if (start) begin
        first = 4'($urandom_range(0, 15));
        last  = 4'($urandom_range(0, 15));
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((c % 2) == 1);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      for (int g = 0; g < 2; g++) begin
        if (!e_err[g] && !fin[g] && !xl[g]) begin
          if (out_valid[g] && out_ready && idx[g] < e_cnt[g]) begin
            check(g, "addr", out_addr[g], e_addr[g][idx[g]]);
            check(g, "data", out_data[g], e_data[g][idx[g]]);
            check(g, "last", out_last[g], (idx[g] == e_cnt[g] - 1));
            if (idx[g] == e_cnt[g] - 1) xl[g] = 1'b1;
            idx[g]++;
          end
          stall[g] = out_valid[g] && !out_ready;
          snap[g]  = {out_valid[g], out_last[g], out_addr[g], out_data[g]};
        end
      end
      if (fin[0] && fin[1]) break;
    end
    start = 1'b0;
    for (int g = 0; g < 2; g++) check(g, "timeout", fin[g], 1'b1);
  endtask

  task automatic check_zero(input string tag);
    for (int g = 0; g < 2; g++)
      check(g, tag, {rs[g], out_data[g], out_addr[g], out_valid[g], out_last[g],
                     busy[g], done[g], err[g]}, 32'd0);
  endtask

  // Reset lands after the second word of a 0..15 scan has been taken
  task automatic reset_test();
    fill_regs();
    @(negedge clk);
    start = 1'b1; first = 4'd0; last = 4'd15; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check(0, "pre_rst_addr", out_addr[0], 4'd2);
    reset = 1'b1;
    #1;
    check_zero("rst_async");
    @(negedge clk);
    check_zero("rst_held");
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_zero("rst_quiet");
    end
    run_scan(0, 15, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; first = 4'd0; last = 4'd0; out_ready = 1'b0;
    for (int i = 0; i < 16; i++) regs[i] = 8'h00;
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    reset = 1'b0;
    @(negedge clk);
    check_zero("idle_state");

    regs[1] = 8'h11; regs[2] = 8'h22; regs[3] = 8'h33;
    run_scan(1, 3, 0);
    fill_regs();
    run_scan(14, 1, 0);
    fill_regs();
    run_scan(0, 15, 1);
    fill_regs();
    run_scan(5, 9, 0);
    fill_regs();
    run_scan(6, 2, 1);
    run_scan(4, 4, 0);
    reset_test();
    for (int i = 0; i < 14; i++) begin
      fill_regs();
      run_scan(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
    end
    for (int i = 0; i < 4; i++) begin
      fill_regs();
      run_scan(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 2);
    end
    regs[1] = 8'hF0; regs[2] = 8'h20; regs[3] = 8'h05;
    run_scan(1, 3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
